// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, state and owner encodings for mem_arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;

  // Big-endian bit numbering to match the CPUX/IOP buses.
  typedef logic [32-ADDR_W:31] addr_t;
  typedef logic [0:DATA_W-1]   data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IOP = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, IOP and RAM signal bundle around mem_arbiter
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_wdata;
  data_t cpu_rdata;
  logic  cpu_ack;

  logic  iop_req;
  logic  iop_we;
  addr_t iop_addr;
  data_t iop_wdata;
  data_t iop_rdata;
  logic  iop_ack;

  addr_t mem_addr;
  logic  mem_we;
  data_t mem_wdata;
  data_t mem_rdata;
  logic  grant_iop;

  // master: the requesters plus the RAM; slave: the arbiter itself.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output iop_req, iop_we, iop_addr, iop_wdata,
    input  iop_rdata, iop_ack,
    input  mem_addr, mem_we, mem_wdata, grant_iop,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  iop_req, iop_we, iop_addr, iop_wdata,
    output iop_rdata, iop_ack,
    output mem_addr, mem_we, mem_wdata, grant_iop,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - owner pick; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else IOP wins ties
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   iop_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_t rr_last,
`endif
  output owner_t owner
);

  always_comb begin
    owner = OWN_CPU;
    if (cpu_req && iop_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      owner = (rr_last == OWN_CPU) ? OWN_IOP : OWN_CPU;
`else
      owner = OWN_IOP;
`endif
    end else if (iop_req) begin
      owner = OWN_IOP;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/IOP arbiter for the single-port main RAM; MEM_ARB_ROUND_ROBIN_EN enables round-robin ties
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int    WAIT_STATES = 0,
  parameter addr_t ADDR_MASK   = 17'h1ffff
)
(
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_t            state;
  owner_t            owner;
  owner_t            pick;
  logic              owner_we;
  logic [WAIT_W-1:0] count;
  logic              any_req;
  logic              pick_we;
  addr_t             pick_addr;
  data_t             pick_wdata;

  assign any_req    = bus.cpu_req | bus.iop_req;
  assign pick_we    = (pick == OWN_IOP) ? bus.iop_we    : bus.cpu_we;
  assign pick_addr  = (pick == OWN_IOP) ? bus.iop_addr  : bus.cpu_addr;
  assign pick_wdata = (pick == OWN_IOP) ? bus.iop_wdata : bus.cpu_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t rr_last;

  // Reset as if the IOP was granted last so the CPU wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last <= OWN_IOP;
    end else if (state == IDLE && any_req) begin
      rr_last <= pick;
    end
  end

  mem_arb_select u_select (
    .cpu_req (bus.cpu_req),
    .iop_req (bus.iop_req),
    .rr_last (rr_last),
    .owner   (pick)
  );
`else
  mem_arb_select u_select (
    .cpu_req (bus.cpu_req),
    .iop_req (bus.iop_req),
    .owner   (pick)
  );
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      owner_we      <= 1'b0;
      count         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.iop_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.iop_ack   <= 1'b0;
      bus.grant_iop <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_we <= 1'b0;
          if (any_req) begin
            owner         <= pick;
            owner_we      <= pick_we;
            count         <= WAIT_INIT;
            bus.mem_addr  <= pick_addr & ADDR_MASK;
            bus.mem_wdata <= pick_wdata;
            // mem_we is registered, so raise it on entry to the last ACCESS cycle.
            bus.mem_we    <= pick_we && (WAIT_INIT == '0);
            bus.grant_iop <= (pick == OWN_IOP);
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count      <= count - WAIT_W'(1);
            bus.mem_we <= owner_we && (count == WAIT_W'(1));
          end else begin
            bus.mem_we <= 1'b0;
            if (owner == OWN_IOP) begin
              bus.iop_ack <= 1'b1;
              if (!owner_we) bus.iop_rdata <= bus.mem_rdata;
            end else begin
              bus.cpu_ack <= 1'b1;
              if (!owner_we) bus.cpu_rdata <= bus.mem_rdata;
            end
            state <= ACK;
          end
        end
        ACK: begin
          bus.cpu_ack   <= 1'b0;
          bus.iop_ack   <= 1'b0;
          bus.grant_iop <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - three arbiters (0, 3, 2 wait states) checked against a transfer-level model
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N     = 3;
  localparam int RAM_N = 1 << ADDR_W;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]         rst_n, cpu_req, cpu_we, cpu_ack, iop_req, iop_we, iop_ack, mem_we, grant_iop;
  logic [N-1:0][15:31]  cpu_addr, iop_addr, mem_addr, peek_addr;
  logic [N-1:0][0:31]   cpu_wdata, cpu_rdata, iop_wdata, iop_rdata, mem_wdata, peek_data;

  int          errors = 0;
  int          checks = 0;
  bit          last_iop [N];
  logic [31:0] mm [int];

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    mem_arbiter_if bus();
    logic [0:31] ram [0:RAM_N-1];
    bit          inited = 1'b0;

    assign bus.cpu_req   = cpu_req[g];
    assign bus.cpu_we    = cpu_we[g];
    assign bus.cpu_addr  = cpu_addr[g];
    assign bus.cpu_wdata = cpu_wdata[g];
    assign bus.iop_req   = iop_req[g];
    assign bus.iop_we    = iop_we[g];
    assign bus.iop_addr  = iop_addr[g];
    assign bus.iop_wdata = iop_wdata[g];
    assign bus.mem_rdata = ram[bus.mem_addr];
    assign cpu_rdata[g]  = bus.cpu_rdata;
    assign cpu_ack[g]    = bus.cpu_ack;
    assign iop_rdata[g]  = bus.iop_rdata;
    assign iop_ack[g]    = bus.iop_ack;
    assign mem_addr[g]   = bus.mem_addr;
    assign mem_we[g]     = bus.mem_we;
    assign mem_wdata[g]  = bus.mem_wdata;
    assign grant_iop[g]  = bus.grant_iop;
    assign peek_data[g]  = ram[peek_addr[g]];

    always @(posedge clock) begin
      if (!inited) begin
        for (int a = 0; a < RAM_N; a++) ram[a] = '0;
        inited = 1'b1;
      end
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end

    mem_arbiter #(.WAIT_STATES(WS), .ADDR_MASK(17'h1ffff)) dut (
      .clock (clock),
      .reset (rst_n[g]),
      .bus   (bus)
    );
  end

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // Tie winner from the rule "the requester not granted most recently".
  function automatic bit tie_iop(input int k);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return !last_iop[k];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] mm_read(input int key);
    return mm.exists(key) ? mm[key] : 32'h0;
  endfunction

  function automatic logic [15:31] rand_addr();
    return 17'($urandom_range(0, 7)) | (17'($urandom_range(0, 1)) << 16);
  endfunction

  // Runs c_n CPU and i_n IOP transfers with the request fields already set; reqs held until done.
  task automatic serve(input int k, input int c_n, input int i_n);
    int cn, ip, lat, we_cnt, key;
    bit first, exp_iop, exp_we, to;
    logic [15:31] a;
    logic [0:31]  wd, c_prev, i_prev, exp_rd;
    cn = c_n; ip = i_n; first = 1'b1; exp_rd = '0;
    cpu_req[k] = (cn > 0);
    iop_req[k] = (ip > 0);
    while (cn > 0 || ip > 0) begin
      exp_iop = (cn > 0 && ip > 0) ? tie_iop(k) : (ip > 0);
      exp_we  = exp_iop ? iop_we[k]    : cpu_we[k];
      a       = exp_iop ? iop_addr[k]  : cpu_addr[k];
      wd      = exp_iop ? iop_wdata[k] : cpu_wdata[k];
      c_prev  = cpu_rdata[k];
      i_prev  = iop_rdata[k];
      lat = 0; we_cnt = 0;
      do begin
        @(posedge clock); #1;
        lat++;
        if (mem_we[k]) we_cnt++;
      end while (!cpu_ack[k] && !iop_ack[k] && lat < 64);
      to = !cpu_ack[k] && !iop_ack[k];
      checks++;
      if (lat != (first ? 2 : 3) + ws_of(k)) begin
        errors++;
        $display("FAIL ack_latency inst=%0d got=%0d want=%0d", k, lat, (first ? 2 : 3) + ws_of(k));
      end
      checks++;
      if ({cpu_ack[k], iop_ack[k]} !== {!exp_iop, exp_iop}) begin
        errors++;
        $display("FAIL ack_owner inst=%0d got cpu_ack=%0b iop_ack=%0b want iop=%0b", k, cpu_ack[k], iop_ack[k], exp_iop);
      end
      checks++;
      if (grant_iop[k] !== exp_iop) begin
        errors++;
        $display("FAIL grant_iop inst=%0d got=%0b want=%0b", k, grant_iop[k], exp_iop);
      end
      checks++;
      if (we_cnt != int'(exp_we)) begin
        errors++;
        $display("FAIL mem_we_cycles inst=%0d got=%0d want=%0d", k, we_cnt, exp_we);
      end
      key = k * RAM_N + int'(a);
      if (exp_we) mm[key] = wd;
      else        exp_rd = mm_read(key);
      checks++;
      if (exp_iop) begin
        if (iop_rdata[k] !== (exp_we ? i_prev : exp_rd) || cpu_rdata[k] !== c_prev) begin
          errors++;
          $display("FAIL rdata inst=%0d got iop=%h cpu=%h want iop=%h cpu=%h", k, iop_rdata[k], cpu_rdata[k], exp_we ? i_prev : exp_rd, c_prev);
        end
      end else begin
        if (cpu_rdata[k] !== (exp_we ? c_prev : exp_rd) || iop_rdata[k] !== i_prev) begin
          errors++;
          $display("FAIL rdata inst=%0d got cpu=%h iop=%h want cpu=%h iop=%h", k, cpu_rdata[k], iop_rdata[k], exp_we ? c_prev : exp_rd, i_prev);
        end
      end
      last_iop[k] = exp_iop;
      if (exp_iop) ip--; else cn--;
      if (to) begin cn = 0; ip = 0; end
      cpu_req[k] = (cn > 0);
      iop_req[k] = (ip > 0);
      first = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  task automatic check_ram(input int k, input logic [15:31] a, input string name);
    peek_addr[k] = a;
    #1;
    checks++;
    if (peek_data[k] !== mm_read(k * RAM_N + int'(a))) begin
      errors++;
      $display("FAIL %s inst=%0d addr=%h got=%h want=%h", name, k, a, peek_data[k], mm_read(k * RAM_N + int'(a)));
    end
  endtask

  task automatic check_zero(input int k, input string name);
    checks++;
    if ({cpu_ack[k], iop_ack[k], mem_we[k], grant_iop[k]} !== 4'b0 || mem_addr[k] !== '0 ||
        mem_wdata[k] !== '0 || cpu_rdata[k] !== '0 || iop_rdata[k] !== '0) begin
      errors++;
      $display("FAIL %s inst=%0d got acks=%b%b we=%b gnt=%b addr=%h wd=%h crd=%h ird=%h want all zero",
               name, k, cpu_ack[k], iop_ack[k], mem_we[k], grant_iop[k], mem_addr[k], mem_wdata[k], cpu_rdata[k], iop_rdata[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = '0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) begin
        cpu_req[k] = 1'($urandom); cpu_we[k] = 1'($urandom);
        iop_req[k] = 1'($urandom); iop_we[k] = 1'($urandom);
        cpu_addr[k] = 17'($urandom); iop_addr[k] = 17'($urandom);
        cpu_wdata[k] = $urandom; iop_wdata[k] = $urandom;
      end
      @(posedge clock); #1;
    end
    for (int k = 0; k < N; k++) check_zero(k, "reset_state");
    cpu_req = '0; iop_req = '0;
    rst_n = '1;
    for (int k = 0; k < N; k++) last_iop[k] = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_write();
    cpu_we[0] = 1'b1; cpu_addr[0] = 17'h00100; cpu_wdata[0] = 32'h00010001;
    serve(0, 1, 0);
    check_ram(0, 17'h00100, "single_write_ram");
  endtask

  task automatic test_read_after_write();
    iop_we[0] = 1'b1; iop_addr[0] = 17'h00040; iop_wdata[0] = 32'hDEADBEEF;
    serve(0, 0, 1);
    cpu_we[0] = 1'b0; cpu_addr[0] = 17'h00040;
    serve(0, 1, 0);
    checks++;
    if (cpu_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cpu_read_after_iop_write got=%h want=deadbeef", cpu_rdata[0]);
    end
  endtask

  task automatic test_simultaneous();
    cpu_we[1] = 1'b0; cpu_addr[1] = 17'h00010;
    iop_we[1] = 1'b1; iop_addr[1] = 17'h00010; iop_wdata[1] = 32'hA5A5_0001;
    serve(1, 2, 2);
  endtask

  task automatic test_wait_read();
    cpu_we[1] = 1'b0; cpu_addr[1] = 17'h00010;
    serve(1, 1, 0);
  endtask

  task automatic test_back_to_back();
    cpu_we[0] = 1'b1; cpu_addr[0] = 17'h00200; cpu_wdata[0] = 32'h1234_5678;
    serve(0, 2, 0);
    iop_we[0] = 1'b0; iop_addr[0] = 17'h00200;
    serve(0, 0, 3);
    check_ram(0, 17'h00200, "back_to_back_ram");
  endtask

  task automatic test_reset_mid();
    int acks;
    cpu_we[2] = 1'b1; cpu_addr[2] = 17'h00077; cpu_wdata[2] = 32'hCAFE_F00D;
    cpu_req[2] = 1'b1;
    @(posedge clock); #1;
    rst_n[2] = 1'b0; cpu_req[2] = 1'b0;
    @(posedge clock); #1;
    check_zero(2, "reset_mid_outputs");
    rst_n[2] = 1'b1;
    last_iop[2] = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (cpu_ack[2] || iop_ack[2] || mem_we[2]) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_mid_no_ack got=%0d active cycles want=0", acks);
    end
    check_ram(2, 17'h00077, "reset_mid_ram");
  endtask

  task automatic test_random();
    int k, cn, ip;
    for (int it = 0; it < 24; it++) begin
      k  = $urandom_range(0, N - 1);
      cn = $urandom_range(0, 2);
      ip = $urandom_range(0, 2);
      if (cn == 0 && ip == 0) cn = 1;
      cpu_we[k] = 1'($urandom); cpu_addr[k] = rand_addr(); cpu_wdata[k] = $urandom;
      iop_we[k] = 1'($urandom); iop_addr[k] = rand_addr(); iop_wdata[k] = $urandom;
      serve(k, cn, ip);
    end
  endtask

  initial begin
    rst_n = '0; cpu_req = '0; iop_req = '0; cpu_we = '0; iop_we = '0;
    cpu_addr = '0; iop_addr = '0; cpu_wdata = '0; iop_wdata = '0; peek_addr = '0;
    test_reset();
    test_single_write();
    test_read_after_write();
    test_simultaneous();
    test_wait_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
